// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data memory access unit: opcode and
// state encodings plus small decode helpers.
package mem_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_WR     = 3'd4
  } state_e;

  function automatic logic is_load(mem_op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  // Word ops need a word-aligned address, halfword ops an even one.
  function automatic logic misaligned(mem_op_e op, logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LW, OP_SW:         bad = (lane != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = lane[0];
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory port bundle of the memory access unit.
// The unit takes the slave modport; the pipeline/memory side takes master.
interface mem_access_unit_if #(
  parameter int OP_W = 3
);

  logic            req_valid;
  logic            req_ready;
  logic [OP_W-1:0] mem_op;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic            resp_valid;
  logic [31:0]     rdata;
  logic            stall;
  logic            addr_err;
  logic            mem_wea;
  logic [31:0]     mem_addra;
  logic [31:0]     mem_dina;
  logic [31:0]     mem_douta;

  modport master (
    output req_valid, mem_op, addr, wdata, mem_douta,
    input  req_ready, resp_valid, rdata, stall, addr_err,
           mem_wea, mem_addra, mem_dina
  );

  modport slave (
    input  req_valid, mem_op, addr, wdata, mem_douta,
    output req_ready, resp_valid, rdata, stall, addr_err,
           mem_wea, mem_addra, mem_dina
  );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge
// into an existing memory word (little-endian lanes).
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Low address bits beyond the access size are ignored here; trapping of
  // misaligned accesses happens before an access ever reaches this logic.
  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (op)
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h0, byte_sel};
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase

    store_word = word;
    case (op)
      OP_SW: store_word = wdata;
      OP_SH: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      OP_SB:   store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-wide data memory without byte enables.
// Optional misaligned-access trap is enabled with `define MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int OP_W       = 3
) (
  input logic              clka,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  import mem_pkg::*;

  state_e      state;
  mem_op_e     op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        resp_q;
  logic        err_q;
  logic        wea_q;
  logic [31:0] rdata_q;
  logic [31:0] addra_q;
  logic [31:0] dina_q;

  logic [OP_W-1:0] op_raw;
  mem_op_e         op_in;
  logic            trap_hit;
  logic            out_of_range;
  logic [31:0]     align_load;
  logic [31:0]     align_store;

  assign op_raw = bus.mem_op;
  assign op_in  = mem_op_e'(op_raw);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_hit = misaligned(op_in, bus.addr[1:0]);
`else
  assign trap_hit = 1'b0;
`endif

  assign out_of_range = (addr_q >> (ADDR_WIDTH + 2)) != 32'h0;

  mem_lane_align u_lane_align (
    .op         (op_q),
    .lane       (addr_q[1:0]),
    .word       (bus.mem_douta),
    .wdata      (wdata_q),
    .load_data  (align_load),
    .store_word (align_store)
  );

  // Write enable and response are registered one state early so they are
  // high during WR / RMW_WR; gating with rst kills them on a mid-op reset.
  always_ff @(posedge clka) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= OP_LW;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
      wea_q   <= 1'b0;
      rdata_q <= '0;
      addra_q <= '0;
      dina_q  <= '0;
    end else begin
      resp_q <= 1'b0;
      err_q  <= 1'b0;
      wea_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= op_in;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            if (trap_hit) begin
              resp_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else begin
              addra_q <= {2'b00, bus.addr[31:2]};
              if (op_in == OP_SW) begin
                dina_q <= bus.wdata;
                wea_q  <= 1'b1;
                resp_q <= 1'b1;
                state  <= ST_WR;
              end else if (is_load(op_in)) begin
                state <= ST_RD;
              end else begin
                state <= ST_RMW_RD;
              end
            end
          end
        end
        ST_RD: begin
          rdata_q <= out_of_range ? 32'h0 : align_load;
          resp_q  <= 1'b1;
          state   <= ST_IDLE;
        end
        ST_RMW_RD: begin
          dina_q <= align_store;
          wea_q  <= 1'b1;
          resp_q <= 1'b1;
          state  <= ST_RMW_WR;
        end
        ST_RMW_WR: state <= ST_IDLE;
        ST_WR:     state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.stall      = bus.req_valid & ~bus.req_ready;
  assign bus.resp_valid = resp_q & ~rst;
  assign bus.mem_wea    = wea_q & ~rst;
  assign bus.addr_err   = err_q;
  assign bus.rdata      = rdata_q;
  assign bus.mem_addra  = addra_q;
  assign bus.mem_dina   = dina_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a 1K-word memory model.
// Honors `define MEM_MISALIGN_TRAP_EN in its reference model.
module tb_mem_access_unit;

  import mem_pkg::*;

  typedef struct {
    int          exp_cyc;
    bit          is_store;
    bit          err;
    logic [31:0] rdata;
    logic [31:0] dina;
    logic [31:0] maddr;
  } exp_t;

  logic        clka = 1'b0;
  logic        rst;
  logic        mem_init;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          busy_until = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] dev_mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  mem_access_unit_if #(.OP_W(3)) bus();

  mem_access_unit #(.ADDR_WIDTH(10), .OP_W(3)) dut (
    .clka (clka),
    .rst  (rst),
    .bus  (bus.slave)
  );

  always #5 clka = ~clka;

  always @(posedge clka) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  function automatic bit in_range(logic [31:0] a);
    return a < 32'd4096;
  endfunction

  // Memory stand-in: asynchronous read, write on the clock edge, zero outside.
  assign bus.mem_douta = (bus.mem_addra < 32'd1024) ? dev_mem[bus.mem_addra[9:0]] : 32'h0;

  always @(posedge clka) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) dev_mem[i] <= init_word(i);
    end else if (bus.mem_wea && bus.mem_addra < 32'd1024) begin
      dev_mem[bus.mem_addra[9:0]] <= bus.mem_dina;
    end
  end

  function automatic bit trap(mem_op_e op, logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    if (op == OP_LW || op == OP_SW) return (a % 4) != 0;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return (a % 2) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(mem_op_e op, logic [31:0] a, logic [31:0] w);
    int unsigned bsh = (a % 4) * 8;
    int unsigned hsh = ((a / 2) % 2) * 16;
    logic [31:0] b = (w >> bsh) & 32'hFF;
    logic [31:0] h = (w >> hsh) & 32'hFFFF;
    case (op)
      OP_LB:   return (b >= 32'd128) ? b - 32'd256 : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32'd32768) ? h - 32'd65536 : h;
      OP_LHU:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(mem_op_e op, logic [31:0] a,
                                            logic [31:0] old, logic [31:0] wd);
    int unsigned bsh = (a % 4) * 8;
    int unsigned hsh = ((a / 2) % 2) * 16;
    logic [31:0] mask;
    case (op)
      OP_SB: begin
        mask = 32'hFF << bsh;
        return (old & ~mask) | ((wd & 32'hFF) << bsh);
      end
      OP_SH: begin
        mask = 32'hFFFF << hsh;
        return (old & ~mask) | ((wd & 32'hFFFF) << hsh);
      end
      default: return wd;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Presents one request (entered and left at posedge+1), waits for accept,
  // then updates the reference model and pushes the expected response.
  task automatic applyStimulus(input mem_op_e op, input logic [31:0] a,
                               input logic [31:0] wd, input bit track);
    exp_t        e;
    int          t;
    int          lat;
    int          busy;
    bit          got;
    logic [31:0] old;
    got = 1'b0;
    bus.req_valid = 1'b1;
    bus.mem_op    = op;
    bus.addr      = a;
    bus.wdata     = wd;
    for (int k = 0; k < 20; k++) begin
      @(negedge clka);
      if (bus.req_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    t = cyc;
    @(posedge clka);
    #1;
    bus.req_valid = 1'b0;
    checkOutput("req_accept", 32'(got), 32'd1);
    if (!got) return;

    old     = in_range(a) ? ref_mem[a[11:2]] : 32'h0;
    e.maddr = {2'b00, a[31:2]};
    e.err   = 1'b0;
    e.rdata = 32'h0;
    e.dina  = 32'h0;
    e.is_store = (op == OP_SW || op == OP_SH || op == OP_SB);
    if (trap(op, a)) begin
      e.err = 1'b1;
      e.is_store = 1'b0;
      lat = 1;
      busy = 0;
    end else if (op == OP_SW) begin
      lat = 1;
      busy = 1;
      e.dina = ref_store(op, a, old, wd);
    end else if (e.is_store) begin
      lat = 2;
      busy = 2;
      e.dina = ref_store(op, a, old, wd);
    end else begin
      lat = 2;
      busy = 1;
      e.rdata = ref_load(op, a, old);
    end
    busy_until = t + busy;
    if (track) begin
      if (e.is_store && in_range(a)) ref_mem[a[11:2]] = e.dina;
      e.exp_cyc = t + lat;
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 10; k++) begin
      @(posedge clka);
      if (sb_q.size() == 0) break;
    end
    #1;
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pop on each response.
  always @(negedge clka) begin
    if (rst === 1'b1) begin
      checkOutput("rst_resp_valid", bus.resp_valid, 1'b0);
      checkOutput("rst_mem_wea", bus.mem_wea, 1'b0);
    end else if (rst === 1'b0) begin
      checkOutput("req_ready", bus.req_ready, 32'(cyc > busy_until));
      checkOutput("stall", bus.stall, 32'(bus.req_valid & !(cyc > busy_until)));
      if (bus.resp_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checkOutput("resp_pending", 32'(sb_q.size()), 32'd1);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput("resp_cycle", 32'(cyc), 32'(mon_e.exp_cyc));
          checkOutput("addr_err", bus.addr_err, 32'(mon_e.err));
          if (mon_e.is_store) begin
            checkOutput("store_wea", bus.mem_wea, 1'b1);
            checkOutput("store_addra", bus.mem_addra, mon_e.maddr);
            checkOutput("store_dina", bus.mem_dina, mon_e.dina);
          end else begin
            checkOutput("load_wea", bus.mem_wea, 1'b0);
            checkOutput("load_rdata", bus.rdata, mon_e.rdata);
          end
        end
      end else begin
        checkOutput("idle_wea", bus.mem_wea, 1'b0);
        if (sb_q.size() > 0 && sb_q[0].exp_cyc < cyc) begin
          checkOutput("resp_missing", 32'(cyc), 32'(sb_q[0].exp_cyc));
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          bad;
    mem_op_e     op;
    logic [31:0] a;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    bus.req_valid = 1'b0;
    bus.mem_op    = OP_LW;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    rst      = 1'b1;
    mem_init = 1'b1;
    repeat (3) @(posedge clka);
    #1;
    rst      = 1'b0;
    mem_init = 1'b0;

    @(negedge clka);
    checkOutput("reset_req_ready", bus.req_ready, 1'b1);
    checkOutput("reset_rdata", bus.rdata, 32'h0);
    checkOutput("reset_addra", bus.mem_addra, 32'h0);
    checkOutput("reset_dina", bus.mem_dina, 32'h0);
    checkOutput("reset_addr_err", bus.addr_err, 1'b0);
    @(posedge clka);
    #1;

    applyStimulus(OP_SW, 32'h10, 32'hDEADBEEF, 1'b1);
    applyStimulus(OP_LW, 32'h10, 32'h0, 1'b1);
    drain();

    applyStimulus(OP_SW, 32'h10, 32'h11223344, 1'b1);
    applyStimulus(OP_SB, 32'h12, 32'h000000AA, 1'b1);
    drain();
    checkOutput("sb_mem_word", dev_mem[4], 32'h11AA3344);

    applyStimulus(OP_SW, 32'h10, 32'h8000FF7F, 1'b1);
    applyStimulus(OP_LB, 32'h10, 32'h0, 1'b1);
    applyStimulus(OP_LB, 32'h11, 32'h0, 1'b1);
    applyStimulus(OP_LBU, 32'h11, 32'h0, 1'b1);
    applyStimulus(OP_LH, 32'h12, 32'h0, 1'b1);
    applyStimulus(OP_LHU, 32'h12, 32'h0, 1'b1);
    drain();

    // Reset lands in the RMW_WR cycle of an SH: no write, no response.
    applyStimulus(OP_SW, 32'h20, 32'h13579BDF, 1'b1);
    drain();
    applyStimulus(OP_SH, 32'h20, 32'h0000BEEF, 1'b0);
    @(posedge clka);
    #1;
    rst = 1'b1;
    @(posedge clka);
    #1;
    rst = 1'b0;
    busy_until = cyc - 1;
    @(negedge clka);
    checkOutput("rst_mid_rmw_word", dev_mem[8], 32'h13579BDF);
    @(posedge clka);
    #1;
    applyStimulus(OP_LW, 32'h20, 32'h0, 1'b1);
    drain();

    applyStimulus(OP_LW, 32'h13, 32'h0, 1'b1);
    drain();

    for (int i = 0; i < 3; i++) applyStimulus(OP_LW, 32'h10, 32'h0, 1'b1);
    drain();

    for (int n = 0; n < 300; n++) begin
      op = mem_op_e'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 255));
      applyStimulus(op, a, $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clka);
        #1;
      end
    end
    drain();
    repeat (3) @(posedge clka);
    #1;

    bad = 0;
    for (int i = 0; i < 1024; i++) if (dev_mem[i] !== ref_mem[i]) bad++;
    checkOutput("mem_contents", 32'(bad), 32'd0);
    checkOutput("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
